// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester arbiter/scheduler.
package arb_pkg;

    // Arbiter FSM: waiting for a request, or holding a grant
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    // Round-robin pointer after reset: requester 7 is highest priority,
    // which makes the first round-robin grant match fixed priority
    localparam logic [IDW-1:0] ROT_INIT = 3'd7;

endpackage

// File: rtl/prio_enc8.sv
// 8-to-3 priority encoder: the highest set bit wins, idx=0 when nothing is set.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] in,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Upward scan so the last (highest) set bit overrides lower ones
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (in[i]) begin
                idx = IDW'(i);
            end
        end
        any = |in;
    end

endmodule

// File: rtl/arb8_sched.sv
// 8-requester arbiter with fixed-priority or round-robin selection, one-hot
// registered grant held until release, and a hold-time watchdog.
module arb8_sched
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            rr_en,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    // Last hold_cnt value before the watchdog forces a release
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    state_t           state_reg;
    logic [IDW-1:0]   ptr_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [IDW-1:0]   gnt_id_reg;
    logic             gnt_valid_reg;
    logic             timeout_reg;

    // Fixed priority is round-robin with the pointer pinned at 7, so one
    // encoder behind the rotate/un-rotate wrapper serves both modes
    logic [IDW-1:0]  eff_ptr;
    logic [NREQ-1:0] req_rot;
    logic [IDW-1:0]  rot_idx;
    logic            rot_any;
    logic [IDW-1:0]  win_id;
    logic            wd_hit;
    logic            release_now;

    assign eff_ptr = rr_en ? ptr_reg : ROT_INIT;

    // Rotate so that req[eff_ptr] lands on bit 7 (highest priority),
    // req[eff_ptr-1] on bit 6, and so on with 3-bit wrap
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW-1:0] src_id;
            assign src_id      = eff_ptr + IDW'(gi + 1);
            assign req_rot[gi] = req[src_id];
        end
    endgenerate

    prio_enc8 u_enc (
        .in  (req_rot),
        .idx (rot_idx),
        .any (rot_any)
    );

    // Un-rotate the encoded position back to a requester index
    assign win_id = rot_idx + eff_ptr + 3'd1;

    assign wd_hit      = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
    assign release_now = done || !req[gnt_id_reg] || wd_hit;

    // Arbitration FSM with all outputs registered; done takes precedence
    // over the watchdog so a normal release never reports a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= ROT_INIT;
            hold_cnt_reg  <= '0;
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg  <= 1'b0;
                    hold_cnt_reg <= '0;
                    if (en && rot_any) begin
                        gnt_reg       <= 8'd1 << win_id;
                        gnt_id_reg    <= win_id;
                        gnt_valid_reg <= 1'b1;
                        state_reg     <= BUSY;
                        if (rr_en) begin
                            ptr_reg <= win_id - 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        gnt_reg       <= '0;
                        gnt_valid_reg <= 1'b0;
                        hold_cnt_reg  <= '0;
                        timeout_reg   <= wd_hit && !done;
                        state_reg     <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        timeout_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = gnt_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_arb8_sched.sv
// Directed bench for arb8_sched with the watchdog limit set to 4 cycles.
module tb_arb8_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rr_en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    arb8_sched #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rr_en     (rr_en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full grant bundle in one go
    task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic t);
        chk({tag, ".gnt"},       32'(gnt),       32'(g));
        chk({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        chk({tag, ".timeout"},   32'(timeout),   32'(t));
    endtask

    int rr_order[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rr_en = 1'b0;
        req   = 8'h00;
        done  = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        chk_gnt("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // rr grant of 5 moves ptr to 4; reset must restore it to 7
        en    = 1'b1;
        rr_en = 1'b1;
        req   = 8'h20;
        step();
        chk_gnt("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 8'hFF;

        // ---------------- round-robin ----------------
        for (int i = 0; i < 9; i++) begin
            step();
            chk_gnt($sformatf("rr%0d", i), 8'(8'd1 << rr_order[i]), 3'(rr_order[i]), 1'b1, 1'b0);
            done = 1'b1;
            step();
            chk_gnt($sformatf("rr%0d_gap", i), 8'h00, 3'(rr_order[i]), 1'b0, 1'b0);
            done = 1'b0;
        end
        req   = 8'h00;
        rr_en = 1'b0;

        // ---------------- fixed priority ----------------
        req = 8'h96;
        step();
        chk_gnt("fix96", 8'h80, 3'd7, 1'b1, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        step();
        chk_gnt("fix96_rel", 8'h00, 3'd7, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h16;
        step();
        chk_gnt("fix16", 8'h10, 3'd4, 1'b1, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        step();
        chk_gnt("fix16_rel", 8'h00, 3'd4, 1'b0, 1'b0);
        done = 1'b0;

        // ---------------- watchdog ----------------
        req = 8'h01;
        step();
        chk_gnt("wd_gnt", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_gnt($sformatf("wd_hold%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step();
        chk_gnt("wd_fire", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        chk_gnt("wd_regnt", 8'h01, 3'd0, 1'b1, 1'b0);

        // ---------------- done/watchdog collision ----------------
        for (int i = 1; i < 4; i++) begin
            step();
            chk_gnt($sformatf("col_hold%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        chk_gnt("col_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h00;
        step();
        chk_gnt("done_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;

        // ---------------- enable gating / abandon ----------------
        en  = 1'b0;
        req = 8'h08;
        step();
        chk_gnt("gate0", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_gnt("gate1", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        chk_gnt("gate_open", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        step();
        chk_gnt("abandon", 8'h00, 3'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
